// File: rtl/rtp_pkg.sv
// Shared RTP definitions for the bitwise packetizer and depacketizer.
// Holds header constants, error/state enums and the header field bundle.
package rtp_pkg;

   localparam logic [1:0] RTP_VERSION   = 2'd2;
   localparam int         RTP_HDR_BYTES = 12;

   typedef enum logic [1:0] {
      ERR_NONE        = 2'b00,
      ERR_VERSION     = 2'b01,
      ERR_UNSUPPORTED = 2'b10,
      ERR_RUNT        = 2'b11
   } rtp_err_e;

   typedef enum logic [1:0] {
      HDR     = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } rtp_state_e;

   typedef struct packed {
      logic        marker;
      logic [6:0]  pt;
      logic [15:0] seq;
      logic [31:0] ts;
      logic [31:0] ssrc;
   } rtp_hdr_t;

   // Only bytes 0 and 1 carry checkable header content.
   function automatic rtp_err_e rtp_hdr_check(
      input logic [3:0] idx,
      input logic [7:0] b,
      input logic       chk_pt,
      input logic [6:0] exp_pt
   );
      rtp_err_e r;
      r = ERR_NONE;
      if (idx == 4'd0) begin
         if (b[7:6] != RTP_VERSION)
            r = ERR_VERSION;
         else if (b[4] || (b[3:0] != 4'd0))
            r = ERR_UNSUPPORTED;
      end else if (idx == 4'd1) begin
         if (chk_pt && (b[6:0] != exp_pt))
            r = ERR_UNSUPPORTED;
      end
      return r;
   endfunction

endpackage

// File: rtl/rtp_byte_serializer.sv
// Byte-to-bit shifter, MSB first, with ready/valid on both sides.
// A byte may reload on the same cycle its last bit is consumed.
module rtp_byte_serializer (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       i_load,
   input  logic [7:0] i_byte,
   input  logic       i_bit_ready,
   output logic       o_bit,
   output logic       o_bit_valid,
   output logic       o_byte_ready,
   output logic       o_consume,
   output logic       o_last_bit
);

   logic [7:0] r_shreg;
   logic [3:0] r_bits_left;

   assign o_bit        = r_shreg[7];
   assign o_bit_valid  = (r_bits_left != 4'd0);
   assign o_consume    = o_bit_valid && i_bit_ready;
   assign o_last_bit   = o_consume && (r_bits_left == 4'd1);
   assign o_byte_ready = (r_bits_left == 4'd0) ||
                         ((r_bits_left == 4'd1) && i_bit_ready);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_shreg     <= 8'd0;
         r_bits_left <= 4'd0;
      end else if (i_load) begin
         r_shreg     <= i_byte;
         r_bits_left <= 4'd8;
      end else if (o_consume) begin
         r_shreg     <= {r_shreg[6:0], 1'b0};
         r_bits_left <= r_bits_left - 4'd1;
      end
   end

endmodule

// File: rtl/rtp_depacketizer.sv
// RTP receive path: parses/validates the 12-byte header from a byte
// stream and serializes the payload as an MSB-first bit stream.
module rtp_depacketizer
   import rtp_pkg::*;
#(
   parameter int EXPECTED_PT = 96,
   parameter bit CHECK_PT    = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  data_in,
   input  logic        valid_in,
   input  logic        last_in,
   output logic        ready_out,
   output logic        bit_out,
   output logic        bit_valid_out,
   input  logic        bit_ready_in,
   output logic        header_valid_out,
   output logic        marker_out,
   output logic [6:0]  payload_type_out,
   output logic [15:0] seq_num_out,
   output logic [31:0] rtp_timestamp_out,
   output logic [31:0] ssrc_out,
   output logic [15:0] payload_bit_count_out,
   output logic        pkt_done_out,
   output logic        seq_gap_out,
   output logic        error_out,
   output logic [1:0]  error_code_out
);

   rtp_state_e r_state, w_state_nxt;
   logic [3:0] r_idx, w_idx_nxt;
   logic       r_last_pend;
   rtp_hdr_t   r_sh, r_fields, w_hdr_new;
   logic       r_first, r_hv, r_pd, r_gap, r_err;
   rtp_err_e   r_code, w_code, w_chk;
   logic [15:0] r_cnt, w_seq_inc;

   logic w_err, w_hdr_done, w_done_set, w_load, w_pend_set;
   logic w_ser_ready, w_ser_consume, w_ser_last_bit;

   rtp_byte_serializer u_ser (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .i_load       (w_load),
      .i_byte       (data_in),
      .i_bit_ready  (bit_ready_in),
      .o_bit        (bit_out),
      .o_bit_valid  (bit_valid_out),
      .o_byte_ready (w_ser_ready),
      .o_consume    (w_ser_consume),
      .o_last_bit   (w_ser_last_bit)
   );

   assign w_chk = rtp_hdr_check(r_idx, data_in, CHECK_PT, 7'(EXPECTED_PT));

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_err       = 1'b0;
      w_code      = ERR_NONE;
      w_hdr_done  = 1'b0;
      w_done_set  = 1'b0;
      w_load      = 1'b0;
      w_pend_set  = 1'b0;
      ready_out   = 1'b0;
      unique case (r_state)
         HDR: begin
            ready_out = 1'b1;
            if (valid_in) begin
               if (w_chk != ERR_NONE) begin
                  w_err       = 1'b1;
                  w_code      = w_chk;
                  w_idx_nxt   = 4'd0;
                  w_state_nxt = last_in ? HDR : DROP;
               end else if (r_idx == 4'(RTP_HDR_BYTES - 1)) begin
                  w_hdr_done = 1'b1;
                  w_idx_nxt  = 4'd0;
                  if (last_in)
                     w_done_set = 1'b1;
                  else
                     w_state_nxt = PAYLOAD;
               end else if (last_in) begin
                  w_err     = 1'b1;
                  w_code    = ERR_RUNT;
                  w_idx_nxt = 4'd0;
               end else begin
                  w_idx_nxt = r_idx + 4'd1;
               end
            end
         end
         PAYLOAD: begin
            // Once the final byte is in, hold off the next packet's bytes.
            ready_out  = w_ser_ready && !r_last_pend;
            w_load     = valid_in && ready_out;
            w_pend_set = w_load && last_in;
            if (w_ser_last_bit && r_last_pend) begin
               w_done_set  = 1'b1;
               w_state_nxt = HDR;
               w_idx_nxt   = 4'd0;
            end
         end
         DROP: begin
            ready_out = 1'b1;
            if (valid_in && last_in) begin
               w_state_nxt = HDR;
               w_idx_nxt   = 4'd0;
            end
         end
         default: begin
            w_state_nxt = HDR;
            w_idx_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= HDR;
         r_idx       <= 4'd0;
         r_last_pend <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_pend_set)
            r_last_pend <= 1'b1;
         else if (w_done_set)
            r_last_pend <= 1'b0;
      end
   end

   always_comb begin
      w_hdr_new           = r_sh;
      w_hdr_new.ssrc[7:0] = data_in;
   end

   assign w_seq_inc = r_fields.seq + 16'd1;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sh     <= '0;
         r_fields <= '0;
         r_first  <= 1'b1;
         r_hv     <= 1'b0;
         r_pd     <= 1'b0;
         r_gap    <= 1'b0;
         r_err    <= 1'b0;
         r_code   <= ERR_NONE;
         r_cnt    <= 16'd0;
      end else begin
         r_hv  <= w_hdr_done;
         r_pd  <= w_done_set;
         r_err <= w_err;
         r_gap <= 1'b0;
         if (w_err)
            r_code <= w_code;
         if ((r_state == HDR) && valid_in) begin
            case (r_idx)
               4'd1:    {r_sh.marker, r_sh.pt} <= data_in;
               4'd2:    r_sh.seq[15:8]   <= data_in;
               4'd3:    r_sh.seq[7:0]    <= data_in;
               4'd4:    r_sh.ts[31:24]   <= data_in;
               4'd5:    r_sh.ts[23:16]   <= data_in;
               4'd6:    r_sh.ts[15:8]    <= data_in;
               4'd7:    r_sh.ts[7:0]     <= data_in;
               4'd8:    r_sh.ssrc[31:24] <= data_in;
               4'd9:    r_sh.ssrc[23:16] <= data_in;
               4'd10:   r_sh.ssrc[15:8]  <= data_in;
               default: ;
            endcase
         end
         if (w_hdr_done) begin
            r_fields <= w_hdr_new;
            r_gap    <= !r_first && (w_hdr_new.seq != w_seq_inc);
            r_first  <= 1'b0;
            r_cnt    <= 16'd0;
         end else if (w_ser_consume) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign header_valid_out      = r_hv;
   assign marker_out            = r_fields.marker;
   assign payload_type_out      = r_fields.pt;
   assign seq_num_out           = r_fields.seq;
   assign rtp_timestamp_out     = r_fields.ts;
   assign ssrc_out              = r_fields.ssrc;
   assign payload_bit_count_out = r_cnt;
   assign pkt_done_out          = r_pd;
   assign seq_gap_out           = r_gap;
   assign error_out             = r_err;
   assign error_code_out        = r_code;

endmodule

// File: doc/rtp_depacketizer.md
Name: rtp_depacketizer

Overview:
Receive-side counterpart of the bitwise RTP packetizer. Accepts an RTP packet as a byte stream with a last-byte flag, and parses and checks the fixed 12-byte header. Exposes header fields (marker, PT, sequence, timestamp, SSRC) and serializes the payload MSB-first as a bit stream with ready/valid backpressure. Sits between the network byte receive path and the bitwise downstream consumer.

Parameters:
EXPECTED_PT, 96, payload type required in the header; a mismatch is a header error.
CHECK_PT, 1, 1 = enforce EXPECTED_PT; 0 = accept any PT.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
data_in  input  8  packet byte
valid_in  input  1  data_in valid
last_in  input  1  qualifies data_in as the final byte of the packet
ready_out  output  1  byte accepted when valid_in && ready_out
bit_out  output  1  payload bit, MSB of each byte first
bit_valid_out  output  1  bit_out valid
bit_ready_in  input  1  downstream consumes bit when bit_valid_out && bit_ready_in
header_valid_out  output  1  one-cycle pulse: header fields updated
marker_out  output  1  RTP M bit
payload_type_out  output  7  RTP PT
seq_num_out  output  16  RTP sequence number
rtp_timestamp_out  output  32  RTP timestamp
ssrc_out  output  32  RTP SSRC
payload_bit_count_out  output  16  payload bits delivered in the current packet
pkt_done_out  output  1  one-cycle pulse: last payload bit consumed (or zero-payload packet ended)
seq_gap_out  output  1  one-cycle pulse, coincident with header_valid_out, when seq != prev_seq+1
error_out  output  1  one-cycle pulse on packet rejection
error_code_out  output  2  01 bad version, 10 unsupported header (CC!=0, X=1, PT mismatch), 11 runt; held until next error

Behaviour:
- Reset: state HDR, byte index 0, all outputs 0, first-packet flag set, shift register empty. Reset mid-packet discards the packet; the following bytes are parsed as a new header.
- State HDR: ready_out=1. Bytes 0..11 are captured into field registers (big-endian). Byte 0 checks: [7:6]==2, X([4])==0, CC([3:0])==0; P([5]) is ignored. Byte 1 supplies {M, PT}.
- Byte 0 failing version -> code 01; failing X/CC, or byte 1 PT mismatch with CHECK_PT=1 -> code 10. In both cases error_out pulses the cycle after the offending byte is accepted. Go to DROP unless that byte had last_in, in which case stay in HDR with index 0.
- last_in on header bytes 0..10 -> error code 11, return to HDR index 0. Header check errors take priority over runt.
- After byte 11 is accepted, the next cycle: header_valid_out=1, fields updated, seq_gap_out evaluated, payload_bit_count_out cleared.
  - seq_gap_out is suppressed when the first-packet flag is set; the flag then clears.
  - 0xFFFF->0x0000 is not a gap.
  - If byte 11 had last_in: zero-payload packet, pkt_done_out pulses with header_valid_out, back to HDR. Otherwise go to PAYLOAD.
- Field outputs hold until the next header_valid_out. Rejected packets do not alter them.
- State PAYLOAD:
  - 8-bit shift register with 4-bit bits_left. bit_valid_out = (bits_left != 0); bit_out = shreg[7].
  - On consume: shift left, bits_left-1, payload_bit_count_out+1 (16-bit, wraps).
  - ready_out = (bits_left==0) || (bits_left==1 && bit_ready_in); this is a combinational path from bit_ready_in. Back-to-back bytes therefore stream at 1 bit/cycle with no bubble.
  - An accepted byte loads shreg and sets bits_left=8. If last_in, latch last_pending.
  - When bits_left goes 1->0 with last_pending: pkt_done_out pulses next cycle, state returns to HDR index 0, last_pending clears.
- State DROP: ready_out=1, bytes discarded, no outputs. On accepted byte with last_in -> HDR index 0.
- valid_in low is legal in any state; no timeout.

Decomposition:
- Shared package rtp_pkg: RTP_VERSION=2, RTP_HDR_BYTES=12, the error code enum (ERR_NONE, ERR_VERSION, ERR_UNSUPPORTED, ERR_RUNT), the state enum (HDR, PAYLOAD, DROP), and the header field struct. The packetizer reuses the package.
- One sub-module, rtp_byte_serializer: the byte-to-bit shift register with bits_left and the ready/valid logic. Parent owns header parsing and the FSM.

Test Plan:
- Bytes 80 E0 00 01 00 00 00 C8 12 34 56 78 AD EF(last), bit_ready_in=1 -> header_valid_out: marker=1, PT=96, seq=1, ts=200, ssrc=0x12345678. Bits 1,0,1,0,1,1,0,1,1,1,1,0,1,1,1,1 on consecutive cycles; payload_bit_count_out=16; pkt_done_out one cycle after the last bit.
- Same packet with bit_ready_in toggling 1/0 -> identical bit sequence, ready_out low while the shift register is busy, no byte lost or duplicated.
- Two packets seq 0xFFFF then 0x0000, then one with seq 0x0005 -> seq_gap_out 0, 0, then 1 on the third header_valid_out.
- Byte 0 = 0x40 then 13 bytes ending last -> error_out with code 01, all bytes absorbed (ready_out=1), no header_valid_out. Next valid packet parses normally.
- last_in on header byte 5 -> error code 11, back to HDR. Byte 0 = 0x81 (CC=1) -> code 10. Byte 1 = 0x61 with CHECK_PT=1 -> code 10.
- rst_in pulsed after 4 payload bits -> outputs zero next cycle, state HDR. Fresh packet parses, seq_gap_out suppressed as first packet.
